// File: rtl/bsr_chain.sv
// Boundary-scan register chain with a shift-length guard on updates.
// The capture/shift stage feeds TDO LSB-first. The update stage drives the
// pins when mode=1. An update is rejected, and a sticky flag is raised,
// unless a full WIDTH bits have been shifted since the last capture.
module bsr_chain #(
    parameter int               WIDTH   = 8,
    parameter bit               GUARD   = 1'b1,
    parameter logic [WIDTH-1:0] UPD_RST = {WIDTH{1'b0}}
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             p_data_in,
    output logic [WIDTH-1:0]             p_data_out,
    input  logic                         s_data_in,
    output logic                         s_data_out,
    input  logic                         mode,
    input  logic                         capture_dr,
    input  logic                         shift_dr,
    input  logic                         update_dr,
    output logic [$clog2(WIDTH+1)-1:0]   shift_cnt,
    output logic                         update_err
);

    localparam int            CW      = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] upd_q, upd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             update_ok_s;

    // Shift one position toward TDO. The new bit enters at the MSB.
    // With WIDTH=1 the result is simply the serial input.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                   input logic            sin);
        logic [WIDTH-1:0] nxt;
        nxt            = cur >> 1;
        nxt[WIDTH-1]   = sin;
        return nxt;
    endfunction

    // Next state of the capture/shift register and its saturating bit counter.
    always_comb begin
        cap_d = cap_q;
        cnt_d = cnt_q;
        if (capture_dr) begin
            cap_d = p_data_in;
            cnt_d = {CW{1'b0}};
        end else if (shift_dr) begin
            cap_d = shift_in(cap_q, s_data_in);
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cap_d = cap_q;
            cnt_d = cnt_q;
        end
    end

    // Guarded update decision on pre-edge state. A same-cycle capture clears the flag last.
    always_comb begin
        upd_d       = upd_q;
        err_d       = err_q;
        update_ok_s = (GUARD == 1'b0) || (cnt_q == CNT_MAX);
        if (update_dr) begin
            if (update_ok_s) begin
                upd_d = cap_q;
                err_d = 1'b0;
            end else begin
                upd_d = upd_q;
                err_d = 1'b1;
            end
        end else begin
            upd_d = upd_q;
            err_d = err_q;
        end
        if (capture_dr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_d;
        end
    end

    // State registers. Reset takes priority over every enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_q <= {WIDTH{1'b0}};
            upd_q <= UPD_RST;
            cnt_q <= {CW{1'b0}};
            err_q <= 1'b0;
        end else begin
            cap_q <= cap_d;
            upd_q <= upd_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Output muxing. Mode switches the pin source without a clock delay.
    always_comb begin
        if (mode) begin
            p_data_out = upd_q;
        end else begin
            p_data_out = p_data_in;
        end
        s_data_out = cap_q[0];
        shift_cnt  = cnt_q;
        update_err = err_q;
    end

endmodule

// File: tb/tb_bsr_chain.sv
// Self-checking bench for bsr_chain. Two instances (guarded / unguarded)
// share one stimulus stream. A queue-based reference model tracks the scan
// path as a FIFO of bits and counts shifts as an unbounded integer.
module tb_bsr_chain;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, mode, s_in, cap_en, sh_en, upd_en;
    logic [W-1:0]  p_in;
    logic [W-1:0]  pout_a, pout_b;
    logic          sout_a, sout_b, err_a, err_b;
    logic [CW-1:0] cnt_a, cnt_b;

    bsr_chain #(.WIDTH(W), .GUARD(1'b1), .UPD_RST(8'hA5)) dut_a (
        .clk(clk), .rst(rst), .p_data_in(p_in), .p_data_out(pout_a),
        .s_data_in(s_in), .s_data_out(sout_a), .mode(mode),
        .capture_dr(cap_en), .shift_dr(sh_en), .update_dr(upd_en),
        .shift_cnt(cnt_a), .update_err(err_a));

    bsr_chain #(.WIDTH(W), .GUARD(1'b0), .UPD_RST(8'h5A)) dut_b (
        .clk(clk), .rst(rst), .p_data_in(p_in), .p_data_out(pout_b),
        .s_data_in(s_in), .s_data_out(sout_b), .mode(mode),
        .capture_dr(cap_en), .shift_dr(sh_en), .update_dr(upd_en),
        .shift_cnt(cnt_b), .update_err(err_b));

    // Reference model state: index 0 = guarded instance, 1 = unguarded
    bit           capq[$];
    int           shifted;
    logic [W-1:0] upd_m [2];
    bit           err_m [2];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] cap_val();
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) v[i] = capq[i];
        return v;
    endfunction

    task automatic model_step();
        logic [W-1:0] old_cap;
        old_cap = cap_val();
        if (rst) begin
            capq.delete();
            for (int i = 0; i < W; i++) capq.push_back(1'b0);
            shifted  = 0;
            upd_m[0] = 8'hA5;
            upd_m[1] = 8'h5A;
            err_m[0] = 1'b0;
            err_m[1] = 1'b0;
        end else begin
            if (upd_en) begin
                for (int g = 0; g < 2; g++) begin
                    if (g == 1 || shifted >= W) begin
                        upd_m[g] = old_cap;
                        err_m[g] = 1'b0;
                    end else begin
                        err_m[g] = 1'b1;
                    end
                end
            end
            if (cap_en) begin
                capq.delete();
                for (int i = 0; i < W; i++) capq.push_back(p_in[i]);
                shifted  = 0;
                err_m[0] = 1'b0;
                err_m[1] = 1'b0;
            end else if (sh_en) begin
                void'(capq.pop_front());
                capq.push_back(s_in);
                shifted++;
            end
        end
    endtask

    task automatic check_all();
        int ec;
        ec = (shifted > W) ? W : shifted;
        check_eq("a_pout", 32'(pout_a), 32'(mode ? upd_m[0] : p_in));
        check_eq("a_sout", 32'(sout_a), 32'(capq[0]));
        check_eq("a_cnt",  32'(cnt_a),  32'(ec));
        check_eq("a_err",  32'(err_a),  32'(err_m[0]));
        check_eq("b_pout", 32'(pout_b), 32'(mode ? upd_m[1] : p_in));
        check_eq("b_sout", 32'(sout_b), 32'(capq[0]));
        check_eq("b_cnt",  32'(cnt_b),  32'(ec));
        check_eq("b_err",  32'(err_b),  32'(err_m[1]));
    endtask

    // One clock: advance model from pre-edge inputs, then sample after the edge
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_capture(input logic [W-1:0] v);
        p_in = v; cap_en = 1'b1; sh_en = 1'b0; upd_en = 1'b0;
        cyc();
        cap_en = 1'b0;
    endtask

    task automatic do_shift(input int n, input logic [31:0] bits);
        for (int i = 0; i < n; i++) begin
            s_in = bits[i]; sh_en = 1'b1;
            cyc();
        end
        sh_en = 1'b0;
    endtask

    task automatic do_update();
        upd_en = 1'b1;
        cyc();
        upd_en = 1'b0;
    endtask

    initial begin
        logic [W-1:0] e;
        rst = 1'b1; mode = 1'b1; s_in = 1'b0; cap_en = 1'b0; sh_en = 1'b0;
        upd_en = 1'b0; p_in = 8'h00;
        #2;

        // 1: reset state
        cyc(); cyc();
        rst = 1'b0;
        check_eq("t1_pout", 32'(pout_a), 32'h000000A5);
        check_eq("t1_sout", 32'(sout_a), 32'h00000000);
        check_eq("t1_cnt",  32'(cnt_a),  32'h00000000);
        check_eq("t1_err",  32'(err_a),  32'h00000000);

        // 2: capture 3C, shift out LSB first
        e = 8'h3C;
        do_capture(e);
        check_eq("t2_sout0", 32'(sout_a), 32'(e[0]));
        for (int i = 1; i < W; i++) begin
            s_in = 1'b0; sh_en = 1'b1;
            cyc();
            check_eq("t2_sout", 32'(sout_a), 32'(e[i]));
        end
        s_in = 1'b0; cyc(); sh_en = 1'b0;
        check_eq("t2_cnt", 32'(cnt_a), 32'h00000008);

        // 3: full shift of 96 then update; then transparent mode
        do_capture(8'h00);
        do_shift(8, 32'h00000096);
        do_update();
        check_eq("t3_pout", 32'(pout_a), 32'h00000096);
        check_eq("t3_err",  32'(err_a),  32'h00000000);
        mode = 1'b0; p_in = 8'h11;
        #1;
        check_eq("t3_transp", 32'(pout_a), 32'h00000011);
        mode = 1'b1;
        #1;

        // 4: short shift rejected when guarded, applied when not
        do_capture(8'hC3);
        do_shift(5, 32'h00000016);
        do_update();
        check_eq("t4_err_a",  32'(err_a),  32'h00000001);
        check_eq("t4_pout_a", 32'(pout_a), 32'h00000096);
        check_eq("t4_err_b",  32'(err_b),  32'h00000000);
        check_eq("t4_pout_b", 32'(pout_b), 32'h000000B6);

        // 5: over-long shift saturates; last 8 bits land in update
        do_capture(8'h00);
        do_shift(12, 32'h000003E7);
        check_eq("t5_cnt", 32'(cnt_a), 32'h00000008);
        do_update();
        check_eq("t5_err",  32'(err_a),  32'h00000000);
        check_eq("t5_pout", 32'(pout_a), 32'h0000003E);

        // 6: capture beats shift; reset mid-shift discards progress
        p_in = 8'hF0; cap_en = 1'b1; sh_en = 1'b1; s_in = 1'b1;
        cyc();
        cap_en = 1'b0; sh_en = 1'b0;
        check_eq("t6_cnt",  32'(cnt_a),  32'h00000000);
        check_eq("t6_sout", 32'(sout_a), 32'h00000000);
        do_shift(8, 32'h000000FF);
        do_capture(8'h7E);
        do_shift(3, 32'h00000005);
        rst = 1'b1; cyc(); rst = 1'b0;
        check_eq("t6_rst_cnt", 32'(cnt_a), 32'h00000000);
        do_update();
        check_eq("t6_rej",     32'(err_a),  32'h00000001);
        check_eq("t6_rst_upd", 32'(pout_a), 32'h000000A5);

        // Random phase: enables, data and occasional reset
        for (int k = 0; k < 800; k++) begin
            rst    = ($urandom_range(0, 63) == 0);
            cap_en = ($urandom_range(0, 19) == 0);
            sh_en  = ($urandom_range(0, 3) != 0);
            upd_en = ($urandom_range(0, 7) == 0);
            mode   = 1'($urandom);
            s_in   = 1'($urandom);
            p_in   = 8'($urandom);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bsr_chain.md
Name: bsr_chain

Overview:
- Parametrised boundary-scan register of WIDTH cells, clocked by a single clock with capture/shift/update enables. No per-cell gated clocks.
- Sits between the TAP controller (source of the DR enables) and the core I/O pins.
- Shifts LSB-first toward TDO.
- Adds a shift-length guard: an update is applied only when at least WIDTH bits have been shifted since the last capture. Otherwise it is rejected and flagged.

Parameters:
- WIDTH, 8, number of boundary-scan cells (>=1).
- GUARD, 1, 1 = reject short-shift updates; 0 = always apply update.
- UPD_RST, 0 (WIDTH bits), reset value of the update register.

Ports:
- clk  input  1  scan clock (TCK domain); all state changes on its rising edge
- rst  input  1  synchronous, active-high reset
- p_data_in  input  WIDTH  parallel data from core/pins
- p_data_out  output  WIDTH  parallel data to pins/core
- s_data_in  input  1  serial in (TDI side)
- s_data_out  output  1  serial out (TDO side)
- mode  input  1  1 = drive p_data_out from update register; 0 = transparent
- capture_dr  input  1  capture enable (TAP Capture-DR)
- shift_dr  input  1  shift enable (TAP Shift-DR)
- update_dr  input  1  update enable (TAP Update-DR), one-cycle pulse
- shift_cnt  output  $clog2(WIDTH+1)  bits shifted since last capture, saturating at WIDTH
- update_err  output  1  sticky flag: last update rejected by guard

Behaviour:
- Reset (rst=1 at clk edge):
  - cap=0, upd=UPD_RST, shift_cnt=0, update_err=0.
  - Reset overrides all enables in that cycle.
- Combinational outputs:
  - p_data_out = mode ? upd : p_data_in.
  - s_data_out = cap[0].
- Capture (capture_dr=1):
  - cap <= p_data_in.
  - shift_cnt <= 0.
  - update_err <= 0.
- Shift (shift_dr=1, capture_dr=0):
  - cap <= {s_data_in, cap[WIDTH-1:1]}.
  - shift_cnt <= min(shift_cnt+1, WIDTH).
  - WIDTH=1 case: cap <= s_data_in.
- Enable priority:
  - capture_dr and shift_dr both high: capture wins; shift is ignored that cycle.
  - Both low: cap and shift_cnt hold.
- Update (update_dr=1):
  - Accepted when GUARD==0 or shift_cnt==WIDTH: upd <= cap; update_err <= 0.
  - Rejected otherwise: upd holds; update_err <= 1.
  - Decision uses pre-edge shift_cnt and cap values.
  - update_dr is independent of capture/shift.
  - Update together with capture in the same cycle: update evaluates the old cap/shift_cnt. Capture's clear of update_err wins over a same-cycle rejection.
- Latency:
  - s_data_out reflects each shifted bit one clk after the shift edge.
  - p_data_out reflects an accepted update one clk after the update edge, when mode=1.
  - Changes to mode are reflected immediately.
- Counter:
  - Saturates at WIDTH and never wraps.
  - Extra shifts beyond WIDTH keep shift_cnt=WIDTH, so an update after shifting through a longer multi-device chain is still accepted.
- Reset mid-shift: partial data is discarded. A later update without a new capture and full shift is rejected (shift_cnt=0), when GUARD=1.

Test Plan:
1. Reset with WIDTH=8, UPD_RST=8'hA5, mode=1 -> p_data_out=8'hA5, s_data_out=0, shift_cnt=0, update_err=0.
2. p_data_in=8'h3C, capture 1 cycle, then 8 shifts with s_data_in=0 -> s_data_out sequence 0,0,1,1,1,1,0,0 (LSB first); shift_cnt=8.
3. Capture, shift in 8'h96 (LSB first), update with mode=1 -> p_data_out=8'h96 one cycle later, update_err=0. Then mode=0 with p_data_in=8'h11 -> p_data_out=8'h11.
4. Capture, only 5 shifts, update (GUARD=1) -> upd unchanged, update_err=1. Repeat with GUARD=0 -> update applied with partially shifted data.
5. Capture, then 12 shifts -> shift_cnt stays 8. Update is accepted, and upd equals the last 8 bits shifted in.
6. capture_dr=1 and shift_dr=1 in the same cycle with p_data_in=8'hF0 -> cap=8'hF0, shift_cnt=0. Then rst asserted mid-shift -> cap=0, shift_cnt=0, and the next update is rejected.
